// File: rtl/run_monitor_pkg.sv
// Shared definitions for the PC run monitor: FSM state encoding,
// the sequential PC increment and the default cycle budget.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int unsigned PC_STEP = 4;

  // Also used by the simulation top as its MAX_CLOCKS.
  localparam int unsigned DEFAULT_MAX_CYCLES = 100000000;

endpackage

// File: rtl/stall_detector.sv
// Tracks the previous valid PC and counts consecutive repeats of it.
// Ports: clk, rst (async low), clear, load (start of run), enable (in RUN),
//   pc_valid, pc_in -> stall_hit; jump_hit only with MONITOR_JUMP_COUNT_EN.
module stall_detector
  import run_monitor_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            enable,
  input  logic            pc_valid,
  input  logic [PC_W-1:0] pc_in,
  output logic            stall_hit
`ifdef MONITOR_JUMP_COUNT_EN
  ,
  output logic            jump_hit
`endif
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  logic [PC_W-1:0] prev_pc;
  logic [SC_W-1:0] stall_cnt;
  logic [SC_W-1:0] cnt_inc;
  logic            same;
  logic            step;

  assign same    = (pc_in == prev_pc);
  assign step    = enable & pc_valid;
  assign cnt_inc = stall_cnt + 1'b1;

  assign stall_hit = step & same &
                     (cnt_inc == SC_W'(STALL_LIMIT));

`ifdef MONITOR_JUMP_COUNT_EN
  logic [PC_W-1:0] seq_pc;

  // Sequential fetch address, wrapping modulo 2^PC_W.
  assign seq_pc   = prev_pc + PC_W'(PC_STEP);
  assign jump_hit = step & ~same & (pc_in != seq_pc);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc   <= '0;
      stall_cnt <= '0;
    end else if (clear) begin
      prev_pc   <= '0;
      stall_cnt <= '0;
    end else if (load) begin
      prev_pc   <= pc_in;
      stall_cnt <= '0;
    end else if (step) begin
      prev_pc   <= pc_in;
      stall_cnt <= same ? cnt_inc : '0;
    end
  end

endmodule

// File: rtl/pc_run_monitor.sv
// Watches the CPU PC stream; flags halt (PC self-loop) or cycle-budget timeout.
// Ports: clk, rst (async low), pc_in, pc_valid, clear -> done, halted,
//   timeout, cycles, halt_pc, state, jump_cnt (counts only with
//   MONITOR_JUMP_COUNT_EN defined, otherwise tied to 0).
module pc_run_monitor
  import run_monitor_pkg::*;
#(
  parameter int          PC_W        = 32,
  parameter int          CNT_W       = 32,
  parameter int unsigned MAX_CYCLES  = DEFAULT_MAX_CYCLES,
  parameter int          STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_valid,
  input  logic             clear,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [PC_W-1:0]  halt_pc,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] jump_cnt
);

  if (STALL_LIMIT < 1) begin : g_bad_limit
    $error("STALL_LIMIT must be at least 1");
  end

  // cycles must never wrap before the budget is reached.
  if (MAX_CYCLES < 1 ||
      (CNT_W < 64 &&
       64'(MAX_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_budget
    $error("MAX_CYCLES must be in 1 .. 2^CNT_W-1");
  end

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cycles_inc;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic             stall_hit;
  logic             budget_hit;
  logic             in_run;
  logic             load;

  assign in_run     = (state_q == ST_RUN);
  assign load       = (state_q == ST_IDLE) & pc_valid;
  assign cycles_inc = cycles_q + 1'b1;
  assign budget_hit = (cycles_inc == CNT_W'(MAX_CYCLES));

`ifdef MONITOR_JUMP_COUNT_EN
  logic jump_hit;
`endif

  stall_detector #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .enable    (in_run),
    .pc_valid  (pc_valid),
    .pc_in     (pc_in),
    .stall_hit (stall_hit)
`ifdef MONITOR_JUMP_COUNT_EN
    ,
    .jump_hit  (jump_hit)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cycles_q  <= '0;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  // Halt is tested before the budget so a same-cycle tie resolves to halt.
  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    halt_pc_d = halt_pc_q;
    if (clear) begin
      state_d   = ST_IDLE;
      cycles_d  = '0;
      halt_pc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pc_valid) begin
            state_d  = ST_RUN;
            cycles_d = CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (pc_valid) begin
            cycles_d = cycles_inc;
            if (stall_hit) begin
              state_d   = ST_HALTED;
              halt_pc_d = pc_in;
            end else if (budget_hit) begin
              state_d = ST_TIMEOUT;
            end
          end
        end
        ST_HALTED: ;
        ST_TIMEOUT: ;
      endcase
    end
  end

`ifdef MONITOR_JUMP_COUNT_EN
  logic [CNT_W-1:0] jump_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_q <= '0;
    end else if (clear) begin
      jump_q <= '0;
    end else if (jump_hit && jump_q != '1) begin
      jump_q <= jump_q + 1'b1;
    end
  end

  assign jump_cnt = jump_q;
`else
  assign jump_cnt = '0;
`endif

  assign state   = state_q;
  assign halted  = (state_q == ST_HALTED);
  assign timeout = (state_q == ST_TIMEOUT);
  assign done    = halted | timeout;
  assign cycles  = cycles_q;
  assign halt_pc = halt_pc_q;

endmodule
